// File: rtl/lens_motor_arbiter_if.sv
// -----------------------------------------------------------------------------
// lens_motor_arbiter_if
// Bundles the request/grant signals exchanged between the requesters (camera
// command decoder, AF trigger/engine, motor driver status) and the lens motor
// arbiter.
//   master : requester side - drives requests and motor status, sees grants
//   slave  : arbiter side   - samples requests, drives grants and status
// Signals:
//   zoom_req, focus_req, af_req : level requests (af_req rising edge arms AF)
//   af_done                     : one-cycle pulse, AF search finished
//   motor_busy                  : driver still moving, holds settle open
//   grant_zoom/focus/af         : one-hot ownership of the motor
//   motor_sel                   : 00 none, 01 zoom, 10 focus, 11 AF
//   settle_busy                 : settle window active
//   af_pending                  : AF armed, waiting for a grant
//   af_timeout                  : one-cycle pulse on AF timeout abort
// -----------------------------------------------------------------------------
interface lens_motor_arbiter_if;
  logic       zoom_req;
  logic       focus_req;
  logic       af_req;
  logic       af_done;
  logic       motor_busy;
  logic       grant_zoom;
  logic       grant_focus;
  logic       grant_af;
  logic [1:0] motor_sel;
  logic       settle_busy;
  logic       af_pending;
  logic       af_timeout;

  modport master (
    output zoom_req, focus_req, af_req, af_done, motor_busy,
    input  grant_zoom, grant_focus, grant_af, motor_sel,
           settle_busy, af_pending, af_timeout
  );

  modport slave (
    input  zoom_req, focus_req, af_req, af_done, motor_busy,
    output grant_zoom, grant_focus, grant_af, motor_sel,
           settle_busy, af_pending, af_timeout
  );
endinterface

// File: rtl/lens_motor_arbiter.sv
// -----------------------------------------------------------------------------
// lens_motor_arbiter
// Fixed-priority arbiter for the shared lens motor driver. Priority is
// zoom > manual focus > auto-focus. Every release passes through a settle
// window (extended while the driver reports motor_busy) before the next
// arbitration. A zoom release re-arms AF so focus is re-acquired after a
// zoom move; manual focus cancels a pending AF.
//
// Optional build macro: LENS_AF_TIMEOUT_EN
//   defined   : AF grants are bounded to AF_TIMEOUT cycles; on expiry
//               af_timeout pulses, the motor is released and AF is not rearmed.
//   undefined : no timeout counter, af_timeout tied low.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : lens_motor_arbiter_if.slave (requests in, grants/status out)
// All outputs are registered; a request sampled in cycle N is granted in N+1.
// -----------------------------------------------------------------------------
module lens_motor_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2950000,
  parameter int unsigned AF_TIMEOUT    = 59000000,
  parameter int          CNT_W         = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  lens_motor_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ZOOM,
    S_FOCUS,
    S_AF,
    S_SETTLE
  } state_t;

  // A zero-length settle window would let a grant follow a release with no
  // mechanical rest at all, so it is stretched to one cycle.
  localparam int unsigned     SETTLE_EFF  = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_EFF - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             af_pending_q, af_pending_d;
  logic             af_timeout_d;
  logic             af_req_q;
  logic             af_rise;

  logic             grant_zoom_q;
  logic             grant_focus_q;
  logic             grant_af_q;
  logic [1:0]       motor_sel_q;
  logic             settle_busy_q;
  logic             af_timeout_q;

`ifdef LENS_AF_TIMEOUT_EN
  localparam logic [CNT_W-1:0] AF_LAST = CNT_W'(AF_TIMEOUT - 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`else
  // AF_TIMEOUT has no effect in this build; the block only references it.
  if (AF_TIMEOUT == 0) begin : g_af_timeout_unused
  end
`endif

  assign af_rise = bus.af_req & ~af_req_q;

  // NOTE: every signal written here gets a default before the case so that no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = '0;  // counter is zero whenever not settling
    af_pending_d = af_pending_q;
    af_timeout_d = 1'b0;
`ifdef LENS_AF_TIMEOUT_EN
    tmo_cnt_d    = '0;
`endif

    // Manual focus owns the lens, so an AF trigger during it is dropped.
    if (af_rise && (state_q != S_FOCUS)) af_pending_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (bus.zoom_req) begin
          state_d = S_ZOOM;
        end else if (bus.focus_req) begin
          state_d      = S_FOCUS;
          af_pending_d = 1'b0;
        end else if (af_pending_q) begin
          state_d      = S_AF;
          af_pending_d = 1'b0;
        end
      end

      S_ZOOM: begin
        if (!bus.zoom_req) begin
          state_d      = S_SETTLE;
          af_pending_d = 1'b1;  // refocus after every zoom move
        end
      end

      S_FOCUS: begin
        if (!bus.focus_req) state_d = S_SETTLE;
      end

      S_AF: begin
        // Preemption is checked before af_done so a zoom landing on the
        // same cycle as completion still rearms AF.
        if (bus.zoom_req) begin
          state_d      = S_SETTLE;
          af_pending_d = 1'b1;
        end else if (bus.focus_req || bus.af_done) begin
          state_d = S_SETTLE;
`ifdef LENS_AF_TIMEOUT_EN
        end else if (tmo_cnt_q == AF_LAST) begin
          state_d      = S_SETTLE;
          af_timeout_d = 1'b1;
          af_pending_d = 1'b0;  // an aborted search is not retried
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
`endif
        end
      end

      S_SETTLE: begin
        // At terminal count the counter parks until the driver is idle.
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = settle_cnt_q;
          if (!bus.motor_busy) state_d = S_IDLE;
        end else begin
          settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d != S_SETTLE) settle_cnt_d = '0;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      settle_cnt_q  <= '0;
      af_pending_q  <= 1'b0;
      af_req_q      <= 1'b0;
      grant_zoom_q  <= 1'b0;
      grant_focus_q <= 1'b0;
      grant_af_q    <= 1'b0;
      motor_sel_q   <= 2'b00;
      settle_busy_q <= 1'b0;
      af_timeout_q  <= 1'b0;
`ifdef LENS_AF_TIMEOUT_EN
      tmo_cnt_q     <= '0;
`endif
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      af_pending_q  <= af_pending_d;
      af_req_q      <= bus.af_req;
      // Outputs are decoded from the next state so they line up with it.
      grant_zoom_q  <= (state_d == S_ZOOM);
      grant_focus_q <= (state_d == S_FOCUS);
      grant_af_q    <= (state_d == S_AF);
      settle_busy_q <= (state_d == S_SETTLE);
      af_timeout_q  <= af_timeout_d;
      case (state_d)
        S_ZOOM:  motor_sel_q <= 2'b01;
        S_FOCUS: motor_sel_q <= 2'b10;
        S_AF:    motor_sel_q <= 2'b11;
        default: motor_sel_q <= 2'b00;
      endcase
`ifdef LENS_AF_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
`endif
    end
  end

  assign bus.grant_zoom  = grant_zoom_q;
  assign bus.grant_focus = grant_focus_q;
  assign bus.grant_af    = grant_af_q;
  assign bus.motor_sel   = motor_sel_q;
  assign bus.settle_busy = settle_busy_q;
  assign bus.af_pending  = af_pending_q;
  assign bus.af_timeout  = af_timeout_q;

endmodule

// File: tb/tb_lens_motor_arbiter.sv
// -----------------------------------------------------------------------------
// tb_lens_motor_arbiter
// Checks lens_motor_arbiter with SETTLE_CYCLES=4, AF_TIMEOUT=10: a table of
// per-cycle vectors for the main arbitration sequences, hand-written sequences
// for the long-AF and asynchronous reset cases, and randomized stimulus
// compared against an ownership/countdown model. Output vector packing:
// {grant_zoom, grant_focus, grant_af, motor_sel[1:0], settle_busy,
//  af_pending, af_timeout}.
// -----------------------------------------------------------------------------
module tb_lens_motor_arbiter;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned AFTMO  = 10;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  lens_motor_arbiter_if bus ();

  lens_motor_arbiter #(
    .SETTLE_CYCLES (SETTLE),
    .AF_TIMEOUT    (AFTMO),
    .CNT_W         (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit       z, f, ar, ad, mb;
    bit [1:0] own;   // 0 none, 1 zoom, 2 focus, 3 AF
    bit       sb, pend;
  } vec_t;

  vec_t vecs[128];
  int   n_vecs;

  function automatic logic [7:0] outs();
    return {bus.grant_zoom, bus.grant_focus, bus.grant_af, bus.motor_sel,
            bus.settle_busy, bus.af_pending, bus.af_timeout};
  endfunction

  function automatic logic [7:0] expv(bit [1:0] own, bit sb, bit pend, bit to);
    return {own == 2'd1, own == 2'd2, own == 2'd3, own, sb, pend, to};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic add(input int n, input bit z, f, ar, ad, mb,
                     input bit [1:0] own, input bit sb, pend);
    for (int k = 0; k < n; k++) begin
      vecs[n_vecs] = '{z:z, f:f, ar:ar, ad:ad, mb:mb, own:own, sb:sb, pend:pend};
      n_vecs++;
    end
  endtask

  task automatic drive(input bit z, f, ar, ad, mb);
    bus.zoom_req   = z;
    bus.focus_req  = f;
    bus.af_req     = ar;
    bus.af_done    = ad;
    bus.motor_busy = mb;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who owns the motor, whether a settle window is running and
  // how far into it we are, plus the AF arming flag.
  // ---------------------------------------------------------------------------
  bit [1:0] m_own;
  bit       m_settling;
  int       m_scnt;
  bit       m_pend;
  bit       m_prev_ar;
  int       m_af_cycles;
  bit       m_to;

  task automatic model_reset();
    m_own = 0; m_settling = 0; m_scnt = 0; m_pend = 0;
    m_prev_ar = 0; m_af_cycles = 0; m_to = 0;
  endtask

  task automatic model_release();
    m_own = 0; m_settling = 1; m_scnt = 0;
  endtask

  task automatic model_step(input bit z, f, ar, ad, mb);
    bit rise;
    bit np;
    rise = ar && !m_prev_ar;
    np   = m_pend;
    m_to = 0;
    if (rise && !(m_own == 2)) np = 1;
    if (m_settling) begin
      if (m_scnt == SETTLE - 1) begin
        if (!mb) m_settling = 0;
      end else begin
        m_scnt++;
      end
    end else begin
      case (m_own)
        2'd0: begin
          if (z) m_own = 1;
          else if (f) begin m_own = 2; np = 0; end
          else if (m_pend) begin m_own = 3; np = 0; m_af_cycles = 0; end
        end
        2'd1: if (!z) begin model_release(); np = 1; end
        2'd2: if (!f) model_release();
        default: begin
          if (z || f || ad) begin
            if (z) np = 1;
            model_release();
          end
`ifdef LENS_AF_TIMEOUT_EN
          else if (m_af_cycles == AFTMO - 1) begin
            model_release();
            m_to = 1;
            np = 0;
          end else begin
            m_af_cycles++;
          end
`endif
        end
      endcase
    end
    m_pend    = np;
    m_prev_ar = ar;
  endtask

  initial begin
    bit z, f, ar, ad, mb;
    n_checks = 0;
    n_errors = 0;
    n_vecs   = 0;

    //            n  z f ar ad mb own sb pend
    add(1,  0,0,0,0,0, 0,0,0);
    add(5,  1,0,0,0,0, 1,0,0);   // zoom granted one cycle after request
    add(4,  0,0,0,0,0, 0,1,1);   // 4 settle cycles, AF armed by zoom release
    add(1,  0,0,0,0,0, 0,0,1);   // IDLE
    add(1,  0,0,0,0,0, 3,0,0);   // AF granted, pending cleared
    add(4,  0,0,0,1,0, 0,1,0);   // af_done -> settle (done only matters in AF)
    add(2,  0,0,0,0,0, 0,0,0);
    add(1,  1,1,0,0,0, 1,0,0);   // zoom beats focus
    add(4,  0,1,0,0,0, 0,1,1);
    add(1,  0,1,0,0,0, 0,0,1);
    add(1,  0,1,0,0,0, 2,0,0);   // focus cancels pending AF
    add(4,  0,0,0,0,0, 0,1,0);
    add(1,  0,0,0,0,0, 0,0,0);
    add(1,  0,0,1,0,0, 0,0,1);   // af_req rising edge arms AF
    add(1,  0,0,1,0,0, 3,0,0);
    add(4,  0,1,1,0,0, 0,1,0);   // focus preempts AF, no rearm
    add(1,  0,1,1,0,0, 0,0,0);
    add(1,  0,1,1,0,0, 2,0,0);
    add(4,  0,0,0,0,0, 0,1,0);
    add(1,  0,0,0,0,1, 0,1,0);   // motor_busy at terminal count holds settle
    add(2,  1,0,0,0,1, 0,1,0);   // zoom during settle not served
    add(1,  1,0,0,0,0, 0,0,0);
    add(1,  1,0,0,0,0, 1,0,0);
    add(4,  0,0,0,0,0, 0,1,1);
    add(1,  0,0,0,0,0, 0,0,1);
    add(1,  0,0,0,0,0, 3,0,0);
    add(4,  1,0,0,0,0, 0,1,1);   // zoom preempts AF, AF rearmed
    add(1,  1,0,0,0,0, 0,0,1);
    add(1,  1,0,0,0,0, 1,0,1);   // zoom beats pending AF
    add(4,  0,0,0,0,0, 0,1,1);
    add(1,  0,0,0,0,0, 0,0,1);
    add(1,  0,0,0,0,0, 3,0,0);
    add(1,  0,0,1,0,0, 3,0,1);   // af_req edge during AF rearms
    add(4,  0,0,1,1,0, 0,1,1);
    add(1,  0,0,1,0,0, 0,0,1);
    add(1,  0,0,1,0,0, 3,0,0);
    add(1,  1,0,1,1,0, 0,1,1);   // done + zoom same cycle: preemption wins
    add(3,  0,0,1,0,0, 0,1,1);
    add(1,  0,0,1,0,0, 0,0,1);
    add(1,  0,0,1,0,0, 3,0,0);
    add(4,  0,0,1,1,0, 0,1,0);
    add(1,  0,0,1,0,0, 0,0,0);

    // Reset state
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", outs(), 8'h00);
    rst = 1'b1;

    // Table vectors: inputs applied after a falling edge, outputs checked at
    // the next falling edge (i.e. after the rising edge that sampled them).
    for (int i = 0; i < n_vecs; i++) begin
      drive(vecs[i].z, vecs[i].f, vecs[i].ar, vecs[i].ad, vecs[i].mb);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(),
            expv(vecs[i].own, vecs[i].sb, vecs[i].pend, 1'b0));
    end

    // Long AF grant with no af_done
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    drive(0, 0, 1, 0, 0);
    @(negedge clk);
    check("af_arm", outs(), expv(0, 0, 1, 0));
    @(negedge clk);
    check("af_long_c1", outs(), expv(3, 0, 0, 0));
`ifdef LENS_AF_TIMEOUT_EN
    for (int k = 2; k <= int'(AFTMO); k++) begin
      @(negedge clk);
      check($sformatf("af_tmo_c%0d", k), outs(), expv(3, 0, 0, 0));
    end
    @(negedge clk);
    check("af_tmo_pulse", outs(), expv(0, 1, 0, 1));
    @(negedge clk);
    check("af_tmo_after", outs(), expv(0, 1, 0, 0));
`else
    for (int k = 2; k <= 60; k++) begin
      @(negedge clk);
      check($sformatf("af_hold_c%0d", k), outs(), expv(3, 0, 0, 0));
    end
    drive(0, 0, 1, 1, 0);
    @(negedge clk);
    check("af_hold_done", outs(), expv(0, 1, 0, 0));
    drive(0, 0, 1, 0, 0);
`endif
    repeat (6) @(negedge clk);
    check("af_back_idle", outs(), expv(0, 0, 0, 0));

    // Asynchronous reset in the middle of a zoom grant
    drive(1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check("zoom_before_rst", outs(), expv(1, 0, 0, 0));
    #2 rst = 1'b0;
    #1 check("async_rst", outs(), 8'h00);
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_held", outs(), 8'h00);
    rst = 1'b1;

    // Randomized stimulus against the model
    model_reset();
    z = 0; f = 0; ar = 0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(9) == 0)  z  = ~z;
      if ($urandom_range(11) == 0) f  = ~f;
      if ($urandom_range(5) == 0)  ar = ~ar;
      ad = ($urandom_range(9) == 0);
      mb = ($urandom_range(2) == 0);
      drive(z, f, ar, ad, mb);
      model_step(z, f, ar, ad, mb);
      @(negedge clk);
      check($sformatf("rand%0d", c), outs(), expv(m_own, m_settling, m_pend, m_to));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
